// File: rtl/dff_pkg.sv
// -----------------------------------------------------------------------------
// dff_pkg
// Shared constants for the dff_pipe register pipeline.
//   DFF_WIDTH   default data width per stage
//   DFF_DEPTH   default number of stages
//   occ_width() bit width of an occupancy counter that spans 0..depth
// -----------------------------------------------------------------------------
package dff_pkg;

    localparam int DFF_WIDTH = 8;
    localparam int DFF_DEPTH = 4;

    // The counter must represent every value 0..depth inclusive, so it needs
    // clog2(depth+1) bits. For example, depth 4 needs 3 bits and depth 1 needs 1 bit.
    function automatic int occ_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/dff_stage.sv
// -----------------------------------------------------------------------------
// dff_stage
// One pipeline stage: a WIDTH-bit data flop plus its valid tag.
// Priority on a rising clk edge: sclr (clear), then en (load), then hold.
//   clk      rising-edge clock
//   rst_n    asynchronous active-low reset, clears data and valid
//   en       load d/d_valid on this edge
//   sclr     synchronous clear, wins over en
//   d        data in
//   d_valid  valid tag in
//   q        registered data
//   q_valid  registered valid tag
// -----------------------------------------------------------------------------
module dff_stage
    import dff_pkg::*;
#(
    parameter int WIDTH = DFF_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             sclr,
    input  logic [WIDTH-1:0] d,
    input  logic             d_valid,
    output logic [WIDTH-1:0] q,
    output logic             q_valid
);

    // NOTE: non-blocking assignments let every stage sample its predecessor's
    // pre-edge value, which is what makes the chain shift by exactly one stage.
    // NOTE: the data bits are reset together with the valid bit. This makes q
    // read as zero during reset, not just invalid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q       <= '0;
            q_valid <= 1'b0;
        end else if (sclr) begin
            q       <= '0;
            q_valid <= 1'b0;
        end else if (en) begin
            q       <= d;
            q_valid <= d_valid;
        end
    end

endmodule

// File: rtl/dff_pipe.sv
// -----------------------------------------------------------------------------
// dff_pipe
// DEPTH-stage, WIDTH-bit edge-triggered register pipeline. Each stage carries a
// valid tag. The pipeline has a global advance enable (en = 0 stalls every
// stage), a synchronous flush (sclr) and an asynchronous active-low reset.
//
// Optional feature: define DFF_PIPE_OCC_EN to add the occ output. occ counts
// the valid stages and always equals popcount of the per-stage valid bits.
//
//   clk      rising-edge clock
//   rst_n    asynchronous active-low reset
//   en       advance the pipeline on this edge
//   sclr     synchronous flush, priority over en
//   d        data into stage 0
//   d_valid  valid tag for d
//   q        data of the last stage
//   q_valid  valid tag of the last stage
//   qbar     bitwise complement of q (combinational)
//   occ      number of valid stages (DFF_PIPE_OCC_EN only)
// -----------------------------------------------------------------------------
module dff_pipe
    import dff_pkg::*;
#(
    parameter int WIDTH = DFF_WIDTH,
    parameter int DEPTH = DFF_DEPTH
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         en,
    input  logic                         sclr,
    input  logic [WIDTH-1:0]             d,
    input  logic                         d_valid,
    output logic [WIDTH-1:0]             q,
    output logic                         q_valid,
    output logic [WIDTH-1:0]             qbar
`ifdef DFF_PIPE_OCC_EN
    ,
    output logic [occ_width(DEPTH)-1:0]  occ
`endif
);

    logic [WIDTH-1:0] stage_data  [DEPTH];
    logic             stage_valid [DEPTH];

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        logic [WIDTH-1:0] din;
        logic             vin;

        if (k == 0) begin : g_head
            assign din = d;
            assign vin = d_valid;
        end else begin : g_link
            assign din = stage_data[k-1];
            assign vin = stage_valid[k-1];
        end

        dff_stage #(.WIDTH(WIDTH)) u_stage (
            .clk     (clk),
            .rst_n   (rst_n),
            .en      (en),
            .sclr    (sclr),
            .d       (din),
            .d_valid (vin),
            .q       (stage_data[k]),
            .q_valid (stage_valid[k])
        );
    end

    assign q       = stage_data[DEPTH-1];
    assign q_valid = stage_valid[DEPTH-1];
    assign qbar    = ~q;

`ifdef DFF_PIPE_OCC_EN
    localparam int OCC_W = occ_width(DEPTH);

    logic [OCC_W-1:0] occ_r;

    // An enabled edge admits one tag at the head and retires one at the tail.
    // The net change is d_valid minus the leaving valid bit. The result stays
    // within 0..DEPTH because it tracks popcount of the stage valid bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ_r <= '0;
        end else if (sclr) begin
            occ_r <= '0;
        end else if (en) begin
            occ_r <= occ_r + OCC_W'(d_valid) - OCC_W'(stage_valid[DEPTH-1]);
        end
    end

    assign occ = occ_r;
`endif

endmodule

// File: tb/tb_dff_pipe.sv
// -----------------------------------------------------------------------------
// tb_dff_pipe
// Self-checking bench for dff_pipe. It tests a WIDTH 8 / DEPTH 4 instance and a
// WIDTH 1 / DEPTH 1 instance. The reference model is a queue of {valid,data}
// words: an enabled edge pushes the new word at the front and drops the oldest.
// -----------------------------------------------------------------------------
module tb_dff_pipe;

    localparam int P_W = 8;
    localparam int P_D = 4;
    localparam int P_OW = $clog2(P_D + 1);

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           en = 1'b0;
    logic           sclr = 1'b0;
    logic [P_W-1:0] d = '0;
    logic           d_valid = 1'b0;
    logic [P_W-1:0] q, qbar;
    logic           q_valid;
    logic [P_OW-1:0] occ;

    logic           d1 = 1'b0;
    logic           dv1 = 1'b0;
    logic           q1, qv1, qb1;
    logic           occ1;

    int vectors = 0;
    int miscompares = 0;

    // Model: index 0 is the newest word and index P_D-1 is the word on q.
    logic [P_W:0] m_q[$];

    always #5 clk = ~clk;

    dff_pipe #(.WIDTH(P_W), .DEPTH(P_D)) dut (
`ifdef DFF_PIPE_OCC_EN
        .occ     (occ),
`endif
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .sclr    (sclr),
        .d       (d),
        .d_valid (d_valid),
        .q       (q),
        .q_valid (q_valid),
        .qbar    (qbar)
    );

    dff_pipe #(.WIDTH(1), .DEPTH(1)) dut1 (
`ifdef DFF_PIPE_OCC_EN
        .occ     (occ1),
`endif
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .sclr    (sclr),
        .d       (d1),
        .d_valid (dv1),
        .q       (q1),
        .q_valid (qv1),
        .qbar    (qb1)
    );

`ifndef DFF_PIPE_OCC_EN
    assign occ  = '0;
    assign occ1 = 1'b0;
`endif

    // ---------------- reference model ----------------
    task automatic model_clear();
        m_q.delete();
        for (int i = 0; i < P_D; i++) m_q.push_back('0);
    endtask

    task automatic model_edge();
        if (sclr) begin
            model_clear();
        end else if (en) begin
            m_q.push_front({d_valid, d});
            void'(m_q.pop_back());
        end
    endtask

    function automatic logic [2*P_W:0] exp_out();
        logic [P_W:0] t;
        t = m_q[P_D-1];
        return {t[P_W], t[P_W-1:0], ~t[P_W-1:0]};
    endfunction

    function automatic logic [P_OW-1:0] exp_occ();
        int n = 0;
        foreach (m_q[i]) n += int'(m_q[i][P_W]);
`ifdef DFF_PIPE_OCC_EN
        return P_OW'(n);
`else
        return '0;
`endif
    endfunction

    task automatic drive(input logic e, input logic s, input logic [P_W-1:0] dd, input logic dv);
        en = e;
        sclr = s;
        d = dd;
        d_valid = dv;
    endtask

    // Rising edge, model update, then settle 1 ns before anything is sampled.
    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        model_clear();
        for (int i = 0; i < 3; i++) begin
            drive(1'($urandom), 1'b0, P_W'($urandom), 1'($urandom));
            #3;
            vectors++;
            if ({q_valid, q, qbar} !== {1'b0, 8'h00, 8'hFF}) begin
                miscompares++;
                $display("FAIL reset_outputs: got qv=%b q=%h qbar=%h want qv=0 q=00 qbar=ff", q_valid, q, qbar);
            end
            vectors++;
            if (occ !== '0) begin
                miscompares++;
                $display("FAIL reset_occ: got %0d want 0", occ);
            end
        end
        @(negedge clk);
        drive(1'b0, 1'b0, '0, 1'b0);
        rst_n = 1'b1;
    endtask

    task automatic test_fill_drain();
        logic [P_W-1:0] vals[4] = '{8'h11, 8'h22, 8'h33, 8'h44};
        for (int e = 0; e < 8; e++) begin
            if (e < 4) drive(1'b1, 1'b0, vals[e], 1'b1);
            else       drive(1'b1, 1'b0, P_W'($urandom), 1'b0);
            tick();
            vectors++;
            if ({q_valid, q, qbar} !== exp_out() || occ !== exp_occ()) begin
                miscompares++;
                $display("FAIL fill_drain edge %0d: got qv=%b q=%h qbar=%h occ=%0d want %h occ=%0d",
                         e + 1, q_valid, q, qbar, occ, exp_out(), exp_occ());
            end
            if (e == 3) begin
                vectors++;
                if ({q_valid, q} !== {1'b1, 8'h11}) begin
                    miscompares++;
                    $display("FAIL fill_first_out: got qv=%b q=%h want qv=1 q=11", q_valid, q);
                end
            end
        end
    endtask

    task automatic test_stall();
        logic [2*P_W:0] held;
        logic [P_OW-1:0] held_occ;
        drive(1'b1, 1'b0, 8'h11, 1'b1); tick();
        drive(1'b1, 1'b0, 8'h22, 1'b1); tick();
        held = {q_valid, q, qbar};
        held_occ = occ;
        for (int e = 0; e < 5; e++) begin
            drive(1'b0, 1'b0, P_W'($urandom), 1'($urandom));
            tick();
            vectors++;
            if ({q_valid, q, qbar} !== held || occ !== held_occ || held !== exp_out()) begin
                miscompares++;
                $display("FAIL stall_hold edge %0d: got %h occ=%0d want %h occ=%0d",
                         e, {q_valid, q, qbar}, occ, exp_out(), exp_occ());
            end
        end
        drive(1'b1, 1'b0, 8'h33, 1'b1); tick();
        drive(1'b1, 1'b0, 8'h44, 1'b1); tick();
        vectors++;
        if ({q_valid, q} !== {1'b1, 8'h11} || occ !== exp_occ()) begin
            miscompares++;
            $display("FAIL stall_resume: got qv=%b q=%h occ=%0d want qv=1 q=11 occ=%0d",
                     q_valid, q, occ, exp_occ());
        end
    endtask

    task automatic test_flush();
        for (int e = 0; e < P_D; e++) begin
            drive(1'b1, 1'b0, P_W'($urandom), 1'b1);
            tick();
        end
        drive(1'b1, 1'b1, 8'h55, 1'b1);
        tick();
        vectors++;
        if ({q_valid, q, qbar} !== {1'b0, 8'h00, 8'hFF} || occ !== '0) begin
            miscompares++;
            $display("FAIL flush: got qv=%b q=%h qbar=%h occ=%0d want qv=0 q=00 qbar=ff occ=0",
                     q_valid, q, qbar, occ);
        end
        for (int e = 0; e < P_D + 1; e++) begin
            drive(1'b1, 1'b0, 8'h00, 1'b0);
            tick();
            vectors++;
            if (q_valid !== 1'b0 || q === 8'h55 || {q_valid, q, qbar} !== exp_out()) begin
                miscompares++;
                $display("FAIL flush_drop edge %0d: got qv=%b q=%h want %h", e, q_valid, q, exp_out());
            end
        end
    endtask

    task automatic test_async_reset();
        drive(1'b1, 1'b0, 8'hA5, 1'b1); tick();
        for (int e = 0; e < P_D - 1; e++) begin
            drive(1'b1, 1'b0, P_W'($urandom), 1'b1);
            tick();
        end
        vectors++;
        if ({q_valid, q} !== {1'b1, 8'hA5}) begin
            miscompares++;
            $display("FAIL async_preload: got qv=%b q=%h want qv=1 q=a5", q_valid, q);
        end
        #2;
        rst_n = 1'b0;
        model_clear();
        #1;
        vectors++;
        if ({q_valid, q, qbar} !== {1'b0, 8'h00, 8'hFF} || occ !== '0) begin
            miscompares++;
            $display("FAIL async_reset: got qv=%b q=%h qbar=%h occ=%0d want qv=0 q=00 qbar=ff occ=0",
                     q_valid, q, qbar, occ);
        end
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b1, 1'b0, 8'h3C, 1'b1);
        for (int e = 0; e < P_D; e++) begin
            tick();
            drive(1'b1, 1'b0, 8'h00, 1'b0);
        end
        vectors++;
        if ({q_valid, q, qbar} !== {1'b1, 8'h3C, 8'hC3} || occ !== exp_occ()) begin
            miscompares++;
            $display("FAIL async_refill: got qv=%b q=%h qbar=%h occ=%0d want qv=1 q=3c qbar=c3 occ=%0d",
                     q_valid, q, qbar, occ, exp_occ());
        end
    endtask

    task automatic test_random();
        for (int e = 0; e < 300; e++) begin
            drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 15) == 0),
                  P_W'($urandom), 1'($urandom));
            tick();
            vectors++;
            if ({q_valid, q, qbar} !== exp_out() || occ !== exp_occ()) begin
                miscompares++;
                $display("FAIL random edge %0d: got %h occ=%0d want %h occ=%0d",
                         e, {q_valid, q, qbar}, occ, exp_out(), exp_occ());
            end
        end
    endtask

    task automatic test_depth1();
        logic prev_d, prev_v;
        drive(1'b1, 1'b0, '0, 1'b0);
        d1 = 1'b0;
        dv1 = 1'b1;
        tick();
        prev_d = 1'b0;
        prev_v = 1'b1;
        for (int e = 0; e < 16; e++) begin
            d1 = ~d1;
            dv1 = 1'($urandom);
            tick();
            vectors++;
            if ({q1, qb1, qv1} !== {prev_d ^ 1'b1, prev_d, dv1} || {q1, qb1, qv1} === {prev_d, ~prev_d, prev_v}) begin
                miscompares++;
                $display("FAIL depth1 edge %0d: got q=%b qbar=%b qv=%b want q=%b qbar=%b qv=%b",
                         e, q1, qb1, qv1, ~prev_d, prev_d, dv1);
            end
            prev_d = d1;
            prev_v = dv1;
        end
    endtask

    initial begin
        model_clear();
        test_reset();
        test_fill_drain();
        test_stall();
        test_flush();
        test_async_reset();
        test_random();
        test_depth1();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not complete within time limit");
        $fatal(1);
    end

endmodule
